// File: rtl/als_pkg.sv
// Shared constants, FSM state type and frame assembly for the ambient-light sensor SPI link.
// The responder and the reader both import this so the frame layout stays in one place.
package als_pkg;

  localparam int unsigned ALS_FRAME_BITS = 16;
  localparam int unsigned ALS_DATA_MSB   = 12;
  localparam int unsigned ALS_DATA_LSB   = 5;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StHold  = 2'd2
  } als_state_e;

  // Places the 8-bit light value at word bits [12:5]; every other bit is zero.
  function automatic logic [ALS_FRAME_BITS-1:0] als_frame_word(input logic [7:0] value);
    logic [ALS_FRAME_BITS-1:0] word;
    word = '0;
    word[ALS_DATA_MSB:ALS_DATA_LSB] = value;
    return word;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input with registered single-cycle
// rise/fall pulses taken from the last sync stage and a history flop.
module sync_edge_det #(
  parameter int unsigned Stages = 2  // must be >= 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q;
  logic              hist_q;
  logic              rise_q;
  logic              fall_q;

  // All flops reset low so a line already low at reset release never looks like a fall.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
      hist_q <= sync_q[Stages-1];
      rise_q <= sync_q[Stages-1] & ~hist_q;
      fall_q <= ~sync_q[Stages-1] & hist_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/als_spi_responder.sv
// SPI responder emulating the ambient-light sensor ADC: oversamples SCLK/CS on clk_12M and
// shifts out {3'b000, light[7:0], 5'b00000} MSB first during each CS-low frame.
module als_spi_responder
  import als_pkg::*;
#(
  parameter int unsigned FRAME_BITS  = ALS_FRAME_BITS,
  parameter int unsigned DATA_MSB    = ALS_DATA_MSB,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_12M,
  input  logic       reset,
  input  logic       sclk_in,
  input  logic       cs_n_in,
  input  logic [7:0] light_value,
  input  logic       light_valid,
  output logic       sdo,
  output logic       sdo_oe,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_abort
);

  localparam int unsigned CntW = $clog2(FRAME_BITS) + 1;

  logic sclk_rise;
  logic sclk_fall_unused;
  logic cs_rise;
  logic cs_fall;

  sync_edge_det #(
    .Stages(SYNC_STAGES)
  ) u_sclk_sync (
    .clk_i (clk_12M),
    .rst_i (reset),
    .d_i   (sclk_in),
    .rise_o(sclk_rise),
    .fall_o(sclk_fall_unused)
  );

  sync_edge_det #(
    .Stages(SYNC_STAGES)
  ) u_cs_sync (
    .clk_i (clk_12M),
    .rst_i (reset),
    .d_i   (cs_n_in),
    .rise_o(cs_rise),
    .fall_o(cs_fall)
  );

  als_state_e            state_q;
  logic [7:0]            hold_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [CntW-1:0]       bit_cnt_q;
  logic                  sdo_q;
  logic                  sdo_oe_q;
  logic                  busy_q;
  logic                  frame_done_q;
  logic                  frame_abort_q;
  logic [FRAME_BITS-1:0] frame_word;

  if (FRAME_BITS == ALS_FRAME_BITS && DATA_MSB == ALS_DATA_MSB) begin : g_pkg_frame
    assign frame_word = als_frame_word(hold_q);
  end else begin : g_gen_frame
    always_comb begin
      frame_word = '0;
      frame_word[DATA_MSB -: 8] = hold_q;
    end
  end

  // hold_q is read with its old value when light_valid coincides with cs_fall, so the
  // frame being loaded carries the previous value and the new one waits for the next frame.
  always_ff @(posedge clk_12M or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      hold_q        <= 8'h00;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      sdo_q         <= 1'b0;
      sdo_oe_q      <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      if (light_valid) begin
        hold_q <= light_value;
      end
      case (state_q)
        StIdle: begin
          if (cs_fall) begin
            state_q   <= StShift;
            shift_q   <= frame_word;
            bit_cnt_q <= '0;
            sdo_q     <= frame_word[FRAME_BITS-1];
            sdo_oe_q  <= 1'b1;
            busy_q    <= 1'b1;
          end else begin
            sdo_q    <= 1'b0;
            sdo_oe_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        end
        StShift: begin
          if (cs_rise) begin
            state_q       <= StIdle;
            frame_abort_q <= 1'b1;
            sdo_q         <= 1'b0;
            sdo_oe_q      <= 1'b0;
            busy_q        <= 1'b0;
          end else if (sclk_rise) begin
            shift_q   <= {shift_q[FRAME_BITS-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == CntW'(FRAME_BITS - 1)) begin
              state_q      <= StHold;
              frame_done_q <= 1'b1;
              sdo_q        <= 1'b0;
            end else begin
              sdo_q <= shift_q[FRAME_BITS-2];
            end
          end
        end
        StHold: begin
          // Extra SCLK rises are ignored here; the pad keeps driving zero until CS rises.
          sdo_q <= 1'b0;
          if (cs_rise) begin
            state_q  <= StIdle;
            sdo_oe_q <= 1'b0;
            busy_q   <= 1'b0;
          end else begin
            sdo_oe_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= StIdle;
          sdo_q    <= 1'b0;
          sdo_oe_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign sdo         = sdo_q;
  assign sdo_oe      = sdo_oe_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;

endmodule
